// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage dcache request/hit handshake with pipeline stall, load capture and sticky halt.
// Define MEM_LLSC_EN to add LL/SC link tracking (SC fails locally without touching the dcache).
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              exm_ren,
  input  logic              exm_wen,
  input  logic [ADDR_W-1:0] exm_addr,
  input  logic [DATA_W-1:0] exm_wdata,
  input  logic              exm_halt,
  input  logic              exm_ll,
  input  logic              exm_sc,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_halted;
  logic [DATA_W-1:0] r_load_data;
  logic w_req, w_load, w_sc_fail, w_drive, w_done;
  logic [DATA_W-1:0] w_sc_data;
  assign w_req  = (exm_ren | exm_wen) & ~r_halted & ~exm_halt;
  assign w_load = exm_ren & ~exm_wen;
  assign w_done = (r_state == IDLE & w_req & (dhit | w_sc_fail)) | (r_state == WAIT & dhit);
`ifdef MEM_LLSC_EN
  logic r_link_valid;
  logic [ADDR_W-1:0] r_link_addr;
  logic w_link_hit;
  assign w_link_hit = r_link_valid & (r_link_addr == exm_addr);
  assign w_sc_fail  = exm_wen & exm_sc & ~w_link_hit;
  assign w_sc_data  = DATA_W'(w_link_hit);
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else if (w_done) begin
      if (w_load & exm_ll) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= exm_addr;
      end else if (exm_wen & (exm_sc | w_link_hit)) begin
        r_link_valid <= 1'b0;
      end
    end
  end
`else
  logic w_unused_ll;
  assign w_unused_ll = exm_ll;
  assign w_sc_fail   = 1'b0;
  assign w_sc_data   = DATA_W'(1);
`endif
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_halted    <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE & exm_halt) r_halted <= 1'b1;
      if (w_done & w_load) r_load_data <= dmemload;
      else if (w_done & exm_wen & exm_sc) r_load_data <= w_sc_data;
    end
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_req ? ((dhit | w_sc_fail) ? DONE : WAIT) : IDLE)
           : r_state == WAIT ? (dhit ? DONE : WAIT)
           : IDLE;
  end
  // A failing SC stalls for its one cycle but never reaches the dcache.
  always_comb begin
    w_drive    = nRST & (r_state != DONE) & w_req & ~w_sc_fail;
    dmemREN    = w_drive & w_load;
    dmemWEN    = w_drive & exm_wen;
    dmemaddr   = w_drive ? exm_addr : '0;
    dmemstore  = w_drive ? exm_wdata : '0;
    mem_stall  = nRST & (r_state == WAIT | (r_state == IDLE & w_req));
    load_valid = nRST & (r_state == DONE);
  end
  assign load_data = r_load_data;
  assign halted    = r_halted;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized transaction-level check of mem_stage_ctrl against a reference model.
module tb_mem_stage_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic exm_ren, exm_wen, exm_halt, exm_ll, exm_sc, dhit;
  logic [31:0] exm_addr, exm_wdata, dmemload;
  logic dmemREN, dmemWEN, mem_stall, load_valid, halted;
  logic [31:0] dmemaddr, dmemstore, load_data;
  int n_chk = 0, n_fail = 0;
  bit m_halted, m_lv;
  logic [31:0] m_ld, m_la;
  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .exm_ren(exm_ren), .exm_wen(exm_wen), .exm_addr(exm_addr),
    .exm_wdata(exm_wdata), .exm_halt(exm_halt), .exm_ll(exm_ll), .exm_sc(exm_sc),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .mem_stall(mem_stall), .load_data(load_data),
    .load_valid(load_valid), .halted(halted)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle_end();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_inputs();
    {exm_ren, exm_wen, exm_halt, exm_ll, exm_sc} = '0;
    exm_addr = '0;
    exm_wdata = '0;
  endtask
  task automatic chk_bus(input string tag, input bit s, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d, input bit lv);
    chk({tag, ".stall"}, mem_stall, s);
    chk({tag, ".ren"}, dmemREN, r);
    chk({tag, ".wen"}, dmemWEN, w);
    chk({tag, ".addr"}, dmemaddr, a);
    chk({tag, ".store"}, dmemstore, d);
    chk({tag, ".lvalid"}, load_valid, lv);
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    dhit = 1'b1;
    @(negedge CLK);
    chk("rst.ren", dmemREN, 0);
    chk("rst.wen", dmemWEN, 0);
    chk("rst.stall", mem_stall, 0);
    cycle_end();
    nRST = 1'b1;
    idle_inputs();
    dhit = 1'b0;
    m_halted = 0; m_lv = 0; m_ld = '0; m_la = '0;
    @(negedge CLK);
    chk("rst.halted", halted, 0);
    chk("rst.lvalid", load_valid, 0);
    chk("rst.ldata", load_data, 0);
    chk("rst.stall_after", mem_stall, 0);
    cycle_end();
  endtask
  task automatic do_op(input bit ren, input bit wen, input bit halt, input bit ll, input bit sc,
                       input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    bit req, ld, scf, sch;
    logic [31:0] loadv;
    exm_ren = ren; exm_wen = wen; exm_halt = halt; exm_ll = ll; exm_sc = sc;
    exm_addr = addr; exm_wdata = wdata;
    req = (ren | wen) && !m_halted && !halt;
    ld = ren && !wen;
    loadv = '0;
    if (!req) begin
      dhit = 1'($urandom);
      dmemload = $urandom;
      @(negedge CLK);
      chk_bus("idle", 0, 0, 0, 0, 0, 0);
      cycle_end();
      if (halt) m_halted = 1;
      chk("halted", halted, m_halted);
      return;
    end
    scf = 0;
    sch = 1;
`ifdef MEM_LLSC_EN
    sch = m_lv && m_la == addr;
    scf = wen && sc && !sch;
`endif
    if (scf) begin
      dhit = 1'($urandom);
      @(negedge CLK);
      chk_bus("scfail", 1, 0, 0, 0, 0, 0);
      cycle_end();
    end else begin
      for (int k = 1; k <= lat; k++) begin
        dhit = (k == lat);
        dmemload = $urandom;
        if (k == lat) loadv = dmemload;
        @(negedge CLK);
        chk_bus("access", 1, ld, wen, addr, wdata, 0);
        cycle_end();
      end
    end
    if (ld) m_ld = loadv;
    else if (wen && sc) m_ld = sch ? 32'd1 : 32'd0;
`ifdef MEM_LLSC_EN
    if (ld && ll) begin
      m_lv = 1;
      m_la = addr;
    end else if (wen && (sc || m_la == addr)) m_lv = 0;
`endif
    dhit = 1'($urandom);
    dmemload = $urandom;
    @(negedge CLK);
    chk_bus("done", 0, 0, 0, 0, 0, 1);
    chk("done.ldata", load_data, m_ld);
    cycle_end();
    chk("halted", halted, m_halted);
  endtask
  logic [31:0] addrs [3] = '{32'h300, 32'h304, 32'h308};
  initial begin
    idle_inputs();
    dhit = 0;
    dmemload = '0;
    cycle_end();
    cycle_end();
    do_reset();
    do_op(1, 0, 0, 0, 0, 32'h100, 32'h0, 1);
    do_op(0, 1, 0, 0, 0, 32'h200, 32'h12345678, 3);
    do_op(1, 1, 0, 0, 0, 32'h204, 32'hCAFEF00D, 2);
    do_op(0, 1, 0, 0, 1, 32'h300, 32'h55, 1);
    do_op(1, 0, 0, 1, 0, 32'h300, 32'h0, 2);
    do_op(0, 1, 0, 0, 1, 32'h300, 32'h66, 1);
    do_op(0, 1, 0, 0, 1, 32'h300, 32'h77, 2);
    // reset while the dcache is still missing
    exm_ren = 1; exm_wen = 0; exm_addr = 32'h400; exm_wdata = 32'h0; dhit = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk_bus("miss", 1, 1, 0, 32'h400, 32'h0, 0);
      cycle_end();
    end
    do_reset();
    do_op(0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
    do_op(1, 0, 0, 0, 0, 32'h500, 32'h0, 1);
    do_op(0, 1, 0, 0, 0, 32'h504, 32'h1, 1);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) do_op(1'($urandom), 1'($urandom), 1, 0, 0, $urandom, $urandom, 1);
      else if (r < 6) do_reset();
      else do_op(1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom),
                 addrs[$urandom_range(0, 2)], $urandom, $urandom_range(1, 4));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
